// File: rtl/pbs_pkg.sv
// Shared types and constants for the battle-system HP datapath.
package pbs_pkg;

    localparam int PBS_HP_W      = 8;
    localparam int PBS_AMT_W     = 8;
    localparam int PBS_P_MAX_HP  = 100;
    localparam int PBS_AI_MAX_HP = 100;

    // Requester indices, also the bit positions in req/done
    localparam logic [1:0] REQ_AI_DMG = 2'd0;
    localparam logic [1:0] REQ_P_DMG  = 2'd1;
    localparam logic [1:0] REQ_HEAL   = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2
    } pbs_state_e;

    typedef enum logic {
        ALU_SUB = 1'b0,
        ALU_ADD = 1'b1
    } pbs_alu_op_e;

    // Reduce a value in 0..5 modulo 3 (requester index wrap 2 -> 0)
    function automatic logic [1:0] pbs_wrap3(input logic [2:0] v);
        logic [2:0] r;
        r = (v >= 3'd3) ? (v - 3'd3) : v;
        return r[1:0];
    endfunction

endpackage

// File: rtl/pbs_hp_arbiter_if.sv
// Request/response bus between the battle controllers and the HP arbiter.
interface pbs_hp_arbiter_if #(
    parameter int HP_W  = 8,
    parameter int AMT_W = 8
);
    logic             load_ai_hp;
    logic [2:0]       req;
    logic [AMT_W-1:0] amt_ai_dmg;
    logic [AMT_W-1:0] amt_p_dmg;
    logic [AMT_W-1:0] amt_heal;
    logic [2:0]       done;
    logic             busy;
    logic [HP_W-1:0]  p_hp;
    logic [HP_W-1:0]  ai_hp;
    logic             p_dead;
    logic             ai_dead;

    // Requester side
    modport master (
        output load_ai_hp, req, amt_ai_dmg, amt_p_dmg, amt_heal,
        input  done, busy, p_hp, ai_hp, p_dead, ai_dead
    );

    // Arbiter side
    modport slave (
        input  load_ai_hp, req, amt_ai_dmg, amt_p_dmg, amt_heal,
        output done, busy, p_hp, ai_hp, p_dead, ai_dead
    );
endinterface

// File: rtl/pbs_hp_sat_alu.sv
// Combinational saturating HP add/sub: damage floors at 0, heal clamps at ceiling.
module pbs_hp_sat_alu
    import pbs_pkg::*;
#(
    parameter int HP_W  = PBS_HP_W,
    parameter int AMT_W = PBS_AMT_W
) (
    input  logic [HP_W-1:0]  hp,
    input  logic [AMT_W-1:0] amt,
    input  pbs_alu_op_e      op,
    input  logic [HP_W-1:0]  ceiling,
    output logic [HP_W-1:0]  result
);
    // One extra bit so the heal sum cannot wrap before the clamp
    localparam int W = ((HP_W > AMT_W) ? HP_W : AMT_W) + 1;

    logic [W-1:0] hp_x;
    logic [W-1:0] amt_x;
    logic [W-1:0] ceil_x;
    logic [W-1:0] sum;

    assign hp_x   = W'(hp);
    assign amt_x  = W'(amt);
    assign ceil_x = W'(ceiling);
    assign sum    = hp_x + amt_x;

    // Select clamped sum or floored difference
    always_comb begin
        result = '0;
        if (op == ALU_ADD)
            result = (sum > ceil_x) ? ceiling : HP_W'(sum);
        else if (amt_x < hp_x)
            result = HP_W'(hp_x - amt_x);
    end
endmodule

// File: rtl/pbs_hp_arbiter.sv
// HP update sequencer: arbitrates three requesters onto one saturating ALU,
// IDLE -> CALC -> WRITE per operation. Define PBS_HP_RR_ARB_EN for
// round-robin arbitration; otherwise fixed priority req[0] > req[1] > req[2].
module pbs_hp_arbiter
    import pbs_pkg::*;
#(
    parameter int HP_W      = PBS_HP_W,
    parameter int AMT_W     = PBS_AMT_W,
    parameter int P_MAX_HP  = PBS_P_MAX_HP,
    parameter int AI_MAX_HP = PBS_AI_MAX_HP
) (
    input  logic           clk,
    input  logic           reset,
    pbs_hp_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_CALC  = CALC;
    localparam logic [1:0] S_WRITE = WRITE;

    localparam logic [HP_W-1:0] P_MAX  = HP_W'(P_MAX_HP);
    localparam logic [HP_W-1:0] AI_MAX = HP_W'(AI_MAX_HP);

    logic [1:0]            state;
    logic [1:0]            idx_q;
    logic [AMT_W-1:0]      amt_q;
    logic [HP_W-1:0]       res_q;
    logic [HP_W-1:0]       p_hp_q;
    logic [HP_W-1:0]       ai_hp_q;

    logic [2:0][AMT_W-1:0] amt_vec;
    logic [1:0]            win_idx;
    logic                  grant;
    logic                  is_heal;
    logic [HP_W-1:0]       alu_hp;
    logic [HP_W-1:0]       alu_res;
    logic [HP_W-1:0]       calc_res;
    pbs_alu_op_e           alu_op;

    assign amt_vec = {bus.amt_heal, bus.amt_p_dmg, bus.amt_ai_dmg};
    // Reload outranks every request, so a grant needs load_ai_hp low
    assign grant   = (state == S_IDLE) && !bus.load_ai_hp && (|bus.req);

`ifdef PBS_HP_RR_ARB_EN
    logic [1:0] rr_ptr;

    // Reverse scan: the last hit is the first requester at or after rr_ptr
    always_comb begin
        win_idx = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (bus.req[pbs_wrap3({1'b0, rr_ptr} + 3'(k))])
                win_idx = pbs_wrap3({1'b0, rr_ptr} + 3'(k));
        end
    end

    // Pointer moves past the winner on every grant, and only then
    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= 2'd0;
        else if (grant)
            rr_ptr <= pbs_wrap3({1'b0, win_idx} + 3'd1);
    end
`else
    // Fixed priority, AI damage first
    always_comb begin
        if (bus.req[0])
            win_idx = REQ_AI_DMG;
        else if (bus.req[1])
            win_idx = REQ_P_DMG;
        else
            win_idx = REQ_HEAL;
    end
`endif

    assign is_heal  = (idx_q == REQ_HEAL);
    assign alu_hp   = (idx_q == REQ_AI_DMG) ? ai_hp_q : p_hp_q;
    assign alu_op   = is_heal ? ALU_ADD : ALU_SUB;
    // A dead player cannot be revived by a heal
    assign calc_res = (is_heal && (p_hp_q == '0)) ? '0 : alu_res;

    pbs_hp_sat_alu #(
        .HP_W  (HP_W),
        .AMT_W (AMT_W)
    ) u_alu (
        .hp      (alu_hp),
        .amt     (amt_q),
        .op      (alu_op),
        .ceiling (P_MAX),
        .result  (alu_res)
    );

    // Sequencer: grant and latch in IDLE, compute in CALC, commit in WRITE
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            idx_q   <= 2'd0;
            amt_q   <= '0;
            res_q   <= '0;
            p_hp_q  <= P_MAX;
            ai_hp_q <= AI_MAX;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.load_ai_hp) begin
                        ai_hp_q <= AI_MAX;
                    end else if (grant) begin
                        idx_q <= win_idx;
                        amt_q <= amt_vec[win_idx];
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    res_q <= calc_res;
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    if (idx_q == REQ_AI_DMG)
                        ai_hp_q <= res_q;
                    else
                        p_hp_q <= res_q;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy    = (state != S_IDLE);
    // Reset during WRITE aborts the commit, so the completion pulse is dropped too
    assign bus.done    = ((state == S_WRITE) && !reset) ? (3'b001 << idx_q) : 3'b000;
    assign bus.p_hp    = p_hp_q;
    assign bus.ai_hp   = ai_hp_q;
    assign bus.p_dead  = (p_hp_q == '0);
    assign bus.ai_dead = (ai_hp_q == '0);
endmodule
